// File: rtl/kernel_pr_fifo_pkg.sv
// kernel_pr_fifo_pkg: shared constants and width helpers for the kernel_pr SRL FIFO family
package kernel_pr_fifo_pkg;
  localparam int FIFO_OUT_COMB = 0;
  localparam int FIFO_OUT_REG = 1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  function automatic int cnt_w(input int depth, input int out_reg);
    return clog2(depth + out_reg + 1);
  endfunction
endpackage

// File: rtl/kernel_pr_fifo_srl_ext_store.sv
// kernel_pr_fifo_srl_ext_store: unreset shift-register array; ce shifts din into entry 0, q reads entry addr
module kernel_pr_fifo_srl_ext_store
  import kernel_pr_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int AW = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [AW-1:0]         addr,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (ce) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  assign q = mem[addr];
endmodule

// File: rtl/kernel_pr_fifo_srl_ext.sv
// kernel_pr_fifo_srl_ext: SRL FIFO with any depth, occupancy count, almost flags and optional registered head (clk/reset, if_write side, if_read side, status)
module kernel_pr_fifo_srl_ext
  import kernel_pr_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int OUT_REG = FIFO_OUT_COMB,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CNT_W = cnt_w(DEPTH, OUT_REG)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  output logic                  if_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic                  if_empty_n,
  output logic [CNT_W-1:0]      if_num_data_valid,
  output logic [CNT_W-1:0]      if_fifo_cap,
  output logic                  if_almost_full_n,
  output logic                  if_almost_empty_n
);
  localparam int CAP = DEPTH + OUT_REG;
  localparam int SW = clog2(DEPTH + 1);
  localparam int AW = clog2(DEPTH);
  logic [SW-1:0] srl_cnt;
  logic [AW-1:0] addr;
  logic [DATA_WIDTH-1:0] q;
  logic head_valid, wr_acc, rd_acc, pop;
  assign if_full_n = srl_cnt != SW'(DEPTH);
  assign wr_acc = if_write & if_write_ce & if_full_n;
  assign rd_acc = if_read & if_read_ce & if_empty_n;
  assign addr = srl_cnt == '0 ? '0 : AW'(srl_cnt - SW'(1));
  always_ff @(posedge clk)
    if (reset) srl_cnt <= '0;
    else srl_cnt <= srl_cnt + SW'(wr_acc) - SW'(pop);
  kernel_pr_fifo_srl_ext_store #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_store (
    .clk (clk),
    .ce  (wr_acc),
    .din (if_din),
    .addr(addr),
    .q   (q)
  );
  if (OUT_REG == FIFO_OUT_REG) begin : g_reg
    logic [DATA_WIDTH-1:0] head;
    assign pop = (~head_valid | rd_acc) & (srl_cnt != '0);
    always_ff @(posedge clk)
      if (reset) begin
        head_valid <= 1'b0;
        head <= '0;
      end else begin
        if (pop) head <= q;
        head_valid <= pop | (head_valid & ~rd_acc);
      end
    assign if_dout = head;
    assign if_empty_n = head_valid;
  end else begin : g_comb
    assign pop = rd_acc;
    assign head_valid = 1'b0;
    assign if_dout = q;
    assign if_empty_n = srl_cnt != '0;
  end
  assign if_num_data_valid = CNT_W'(srl_cnt) + CNT_W'(head_valid);
  assign if_fifo_cap = CNT_W'(CAP);
  assign if_almost_full_n = if_num_data_valid < CNT_W'(AF_LEVEL);
  assign if_almost_empty_n = if_num_data_valid > CNT_W'(AE_LEVEL);
endmodule

// File: tb/tb_kernel_pr_fifo_srl_ext.sv
// tb_kernel_pr_fifo_srl_ext: directed scoreboard bench over comb depth-4, comb depth-5 and registered depth-4 FIFOs
module tb_kernel_pr_fifo_srl_ext;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  int total = 0, fails = 0;
  logic [7:0] qa[$], qb[$], qc[$];
  logic [7:0] a_din = '0, a_dout, b_din = '0, b_dout, c_din = '0, c_dout;
  logic a_wr = 0, a_wce = 1, a_rd = 0, a_rce = 1, a_full_n, a_empty_n, a_af_n, a_ae_n;
  logic b_wr = 0, b_wce = 1, b_rd = 0, b_rce = 1, b_full_n, b_empty_n, b_af_n, b_ae_n;
  logic c_wr = 0, c_wce = 1, c_rd = 0, c_rce = 1, c_full_n, c_empty_n, c_af_n, c_ae_n;
  logic [2:0] a_cnt, a_cap, b_cnt, b_cap, c_cnt, c_cap;
  kernel_pr_fifo_srl_ext #(.DATA_WIDTH(8), .DEPTH(4), .OUT_REG(0)) u_a (
    .clk(clk), .reset(reset), .if_din(a_din), .if_write(a_wr), .if_write_ce(a_wce), .if_full_n(a_full_n),
    .if_dout(a_dout), .if_read(a_rd), .if_read_ce(a_rce), .if_empty_n(a_empty_n), .if_num_data_valid(a_cnt),
    .if_fifo_cap(a_cap), .if_almost_full_n(a_af_n), .if_almost_empty_n(a_ae_n));
  kernel_pr_fifo_srl_ext #(.DATA_WIDTH(8), .DEPTH(5), .OUT_REG(0)) u_b (
    .clk(clk), .reset(reset), .if_din(b_din), .if_write(b_wr), .if_write_ce(b_wce), .if_full_n(b_full_n),
    .if_dout(b_dout), .if_read(b_rd), .if_read_ce(b_rce), .if_empty_n(b_empty_n), .if_num_data_valid(b_cnt),
    .if_fifo_cap(b_cap), .if_almost_full_n(b_af_n), .if_almost_empty_n(b_ae_n));
  kernel_pr_fifo_srl_ext #(.DATA_WIDTH(8), .DEPTH(4), .OUT_REG(1)) u_c (
    .clk(clk), .reset(reset), .if_din(c_din), .if_write(c_wr), .if_write_ce(c_wce), .if_full_n(c_full_n),
    .if_dout(c_dout), .if_read(c_rd), .if_read_ce(c_rce), .if_empty_n(c_empty_n), .if_num_data_valid(c_cnt),
    .if_fifo_cap(c_cap), .if_almost_full_n(c_af_n), .if_almost_empty_n(c_ae_n));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [7:0] nv;
    tick;
    tick;
    reset = 1'b0;
    chk("rst_a_empty_n", a_empty_n, 0);
    chk("rst_a_full_n", a_full_n, 1);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_af_n", a_af_n, 1);
    chk("rst_a_ae_n", a_ae_n, 0);
    chk("rst_a_cap", a_cap, 4);
    chk("rst_b_cap", b_cap, 5);
    chk("rst_c_cap", c_cap, 5);
    chk("rst_c_dout", c_dout, 0);
    chk("rst_c_empty_n", c_empty_n, 0);
    for (int i = 0; i < 4; i++) begin
      a_din = 8'(8'h11 * (i + 1));
      a_wr = 1'b1;
      qa.push_back(a_din);
      tick;
      if (i == 0) begin
        chk("fill_a_empty_n", a_empty_n, 1);
        chk("fill_a_first_dout", a_dout, 8'h11);
      end
      chk("fill_a_cnt", a_cnt, i + 1);
      chk("fill_a_af_n", a_af_n, (i + 1) < 3);
    end
    a_wr = 1'b0;
    chk("full_a_full_n", a_full_n, 0);
    a_din = 8'h55;
    a_wr = 1'b1;
    a_rd = 1'b1;
    chk("full_rw_dout", a_dout, qa.pop_front());
    tick;
    a_wr = 1'b0;
    a_rd = 1'b0;
    chk("full_rw_cnt", a_cnt, 3);
    chk("full_rw_full_n", a_full_n, 1);
    a_din = 8'h66;
    a_wr = 1'b1;
    a_wce = 1'b0;
    a_rd = 1'b1;
    a_rce = 1'b0;
    tick;
    a_wr = 1'b0;
    a_rd = 1'b0;
    a_wce = 1'b1;
    a_rce = 1'b1;
    chk("ce_cnt", a_cnt, 3);
    chk("ce_dout", a_dout, qa[0]);
    while (qa.size() > 0) begin
      chk("drain_a_cnt", a_cnt, qa.size());
      chk("drain_a_ae_n", a_ae_n, qa.size() > 1);
      a_rd = 1'b1;
      chk("drain_a_dout", a_dout, qa.pop_front());
      tick;
    end
    a_rd = 1'b0;
    chk("drain_a_empty_n", a_empty_n, 0);
    a_wr = 1'b1;
    a_rd = 1'b1;
    tick;
    a_wr = 1'b0;
    a_rd = 1'b0;
    chk("empty_rw_cnt", a_cnt, 1);
    chk("empty_rw_dout", a_dout, a_din);
    for (int i = 0; i < 2; i++) begin
      b_din = 8'(i);
      b_wr = 1'b1;
      qb.push_back(b_din);
      tick;
    end
    nv = 8'd2;
    for (int i = 0; i < 20; i++) begin
      b_din = nv;
      b_wr = 1'b1;
      b_rd = 1'b1;
      qb.push_back(nv);
      chk("stream_b_dout", b_dout, qb.pop_front());
      tick;
      chk("stream_b_cnt", b_cnt, 2);
      nv++;
    end
    b_wr = 1'b0;
    b_rd = 1'b0;
    c_din = 8'hA5;
    c_wr = 1'b1;
    qc.push_back(c_din);
    tick;
    c_wr = 1'b0;
    chk("c_lat1_empty_n", c_empty_n, 0);
    chk("c_lat1_cnt", c_cnt, 1);
    tick;
    chk("c_lat2_empty_n", c_empty_n, 1);
    chk("c_lat2_dout", c_dout, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      chk("c_fill_full_n", c_full_n, 1);
      c_din = 8'(8'hB0 + i);
      c_wr = 1'b1;
      qc.push_back(c_din);
      tick;
    end
    chk("c_full_full_n", c_full_n, 0);
    chk("c_full_cnt", c_cnt, 5);
    chk("c_full_af_n", c_af_n, 0);
    c_din = 8'hEE;
    tick;
    c_wr = 1'b0;
    chk("c_overfill_cnt", c_cnt, 5);
    while (qc.size() > 0) begin
      c_rd = 1'b1;
      chk("c_drain_dout", c_dout, qc.pop_front());
      tick;
      chk("c_drain_cnt", c_cnt, qc.size());
    end
    c_rd = 1'b0;
    chk("c_drain_empty_n", c_empty_n, 0);
    a_rd = 1'b1;
    tick;
    a_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_din = 8'(8'hC0 + i);
      a_wr = 1'b1;
      tick;
    end
    chk("prerst_a_cnt", a_cnt, 3);
    reset = 1'b1;
    a_rd = 1'b1;
    tick;
    reset = 1'b0;
    a_wr = 1'b0;
    a_rd = 1'b0;
    chk("midrst_cnt", a_cnt, 0);
    chk("midrst_empty_n", a_empty_n, 0);
    chk("midrst_full_n", a_full_n, 1);
    chk("midrst_ae_n", a_ae_n, 0);
    chk("midrst_af_n", a_af_n, 1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/kernel_pr_fifo_srl_ext.md
Name: kernel_pr_fifo_srl_ext

Overview:
Next-generation shift-register FIFO for kernel_pr inter-process channels: start tokens and narrow data streams between dataflow processes. Keeps the existing empty_n/full_n/read_ce/write_ce handshake and adds:
- arbitrary (non-power-of-2) depth
- occupancy count
- programmable almost-full/almost-empty flags
- optional registered output stage for timing closure
Drop-in for the per-process start FIFOs when OUT_REG=0.

Parameters:
DATA_WIDTH, 1, width of if_din/if_dout (1..512).
DEPTH, 4, SRL entries (>=2, any integer).
OUT_REG, 0, 0 = combinational SRL read port; 1 = registered head register (capacity DEPTH+1).
AF_LEVEL, DEPTH-1, if_almost_full_n deasserts when count >= AF_LEVEL.
AE_LEVEL, 1, if_almost_empty_n deasserts when count <= AE_LEVEL.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
if_din  in  DATA_WIDTH  write data.
if_write  in  1  write request.
if_write_ce  in  1  write clock enable; write accepted = if_write & if_write_ce & if_full_n.
if_full_n  out  1  1 = space available.
if_dout  out  DATA_WIDTH  head-of-queue data, valid while if_empty_n=1.
if_read  in  1  read request.
if_read_ce  in  1  read clock enable; read accepted = if_read & if_read_ce & if_empty_n.
if_empty_n  out  1  1 = data available.
if_num_data_valid  out  CNT_W  total entries held (SRL plus head register); CNT_W = clog2(CAP+1), CAP = DEPTH+OUT_REG.
if_fifo_cap  out  CNT_W  constant CAP.
if_almost_full_n  out  1  0 when if_num_data_valid >= AF_LEVEL.
if_almost_empty_n  out  1  0 when if_num_data_valid <= AE_LEVEL.

Behaviour:
- Reset values (all outputs registered or driven from registered state):
  - if_empty_n=0, if_full_n=1, if_num_data_valid=0, if_almost_full_n=1, if_almost_empty_n=0.
  - OUT_REG=1: head register clears to 0.
  - OUT_REG=0: if_dout is don't-care until the first write (SRL contents are not reset).
- Reset mid-operation: all stored data is discarded in that cycle and flags return to reset values. Requests asserted during the reset cycle are ignored.
- Storage:
  - Accepted write shifts the SRL: entry 0 takes if_din, entry i+1 takes entry i.
  - Read address = srl_cnt-1 (oldest entry); address 0 when srl_cnt=0.
- OUT_REG=0:
  - if_full_n=0 iff count=DEPTH; if_empty_n=1 iff count>0.
  - Write-to-empty_n latency 1 cycle; if_dout valid in the same cycle empty_n rises.
  - Write only: count+1. Read only: count-1. Both accepted: count unchanged, shift occurs, head advances correctly.
  - Full: write is not accepted; a read in the same cycle is accepted and if_full_n returns to 1 next cycle.
  - Empty: a read is not accepted.
- OUT_REG=1:
  - Head register with valid bit drives if_dout; if_empty_n = head valid.
  - Head loads from SRL oldest entry when (head empty or read accepted) and srl_cnt>0; srl_cnt decrements on load.
  - No bypass: write into an empty FIFO raises if_empty_n 2 cycles after acceptance.
  - if_full_n=0 iff srl_cnt=DEPTH.
  - Read accepted with srl_cnt=0: head valid clears next cycle.
  - Simultaneous write, load and read keep ordering: SRL shift and address computed from pre-edge srl_cnt.
- Count and flags:
  - if_num_data_valid = srl_cnt + head_valid, updated on the clock edge after the accepting edge.
  - Almost flags are decoded from the registered count, so they change in the same cycle as the count.
  - Count never wraps; overflow and underflow are impossible by construction of the accept terms.

Decomposition:
- Shared package/header kernel_pr_fifo_pkg:
  - clog2 constant function
  - OUT_REG mode constants (FIFO_OUT_COMB=0, FIFO_OUT_REG=1)
  - CNT_W derivation
- One sub-module, kernel_pr_fifo_srl_ext_store: parametrised SRL array with ce/addr/q, no reset.
- Control, count, head register and flag decode live in the top module.

Test Plan:
- DATA_WIDTH=8, DEPTH=4, OUT_REG=0: write 0x11,0x22,0x33,0x44 on consecutive cycles -> if_empty_n=1 one cycle after the first write; if_full_n=0 after the 4th; if_num_data_valid=4; if_almost_full_n=0 from count 3.
- Same config, full, then assert write 0x55 and read together -> read returns 0x11; 0x55 is dropped; count=3; if_full_n=1 next cycle.
- DEPTH=5 (non-power-of-2), count=2: 20 cycles of continuous simultaneous read/write with an incrementing pattern -> count stays 2; output sequence is strictly in order with no gaps.
- OUT_REG=1, DEPTH=4: single write 0xA5 into an empty FIFO -> if_empty_n rises exactly 2 cycles later with if_dout=0xA5. Fill to 5 entries -> if_full_n=0, if_fifo_cap=5.
- if_write_ce=0 with if_write=1, and if_read_ce=0 with if_read=1 -> no state change.
- Reset asserted with 3 entries held -> next cycle count=0, if_empty_n=0, if_full_n=1, if_almost_empty_n=0.
